// File: rtl/if_stage_prefetch.sv
// Prefetching instruction-fetch stage: keeps several SRAM-like requests in flight
// and queues returned instructions in a small buffer ahead of ID.
module if_stage_prefetch #(
  parameter logic [31:0] PC_RESET        = 32'h1c000000,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          IBUF_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        br_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [64:0] fs_to_ds_bus,
  input  logic        expt_clear,
  input  logic [31:0] expt_refresh_pc
);

  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int IW  = $clog2(IBUF_DEPTH + 1);
  localparam int OPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int IPW = $clog2(IBUF_DEPTH);

  logic [31:0]    pf_pc_reg;
  logic [OW-1:0]  inflight_reg, inflight_next;
  logic [OW-1:0]  dcnt_reg;
  logic [IW-1:0]  icnt_reg;
  logic           adef_hold_reg;
  logic [OPW-1:0] ofifo_wr_reg, ofifo_rd_reg, ofifo_wr_next, ofifo_rd_next;
  logic [IPW-1:0] ibuf_wr_reg, ibuf_rd_reg;
  logic [31:0]    ofifo_mem [MAX_OUTSTANDING];
  logic [64:0]    ibuf_mem  [IBUF_DEPTH];

  logic [OW-1:0]  live;
  logic           redirect, misaligned, accept, resp, resp_keep, adef_push;
  logic           ibuf_push, ibuf_pop;
  logic [64:0]    ibuf_din;

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;
  assign inst_sram_addr  = pf_pc_reg;
  assign fs_to_ds_bus    = ibuf_mem[ibuf_rd_reg];

  // Credit excludes responses already marked for discard, so the buffer can never overflow.
  always_comb begin
    live       = inflight_reg - dcnt_reg;
    redirect   = expt_clear | br_taken;
    misaligned = pf_pc_reg[1:0] != 2'b00;
    inst_sram_req = ~reset & ~br_stall & ~redirect & ~adef_hold_reg & ~misaligned
                  & (32'(inflight_reg) < 32'(MAX_OUTSTANDING))
                  & ((32'(live) + 32'(icnt_reg)) < 32'(IBUF_DEPTH));
    accept     = inst_sram_req & inst_sram_addr_ok;
    resp       = inst_sram_data_ok & (inflight_reg != '0);
    resp_keep  = resp & (dcnt_reg == '0) & ~redirect;
    adef_push  = ~reset & ~redirect & misaligned & ~adef_hold_reg & (live == '0)
               & (32'(icnt_reg) < 32'(IBUF_DEPTH));
    ibuf_push  = resp_keep | adef_push;
    ibuf_din   = adef_push ? {1'b1, pf_pc_reg, 32'h0}
                           : {1'b0, ofifo_mem[ofifo_rd_reg], inst_sram_rdata};
    fs_to_ds_valid = ~reset & (icnt_reg != '0) & ~redirect;
    ibuf_pop   = fs_to_ds_valid & ds_allowin;
    inflight_next = inflight_reg + OW'(accept) - OW'(resp);
    ofifo_wr_next = (ofifo_wr_reg == OPW'(MAX_OUTSTANDING - 1)) ? '0 : ofifo_wr_reg + 1'b1;
    ofifo_rd_next = (ofifo_rd_reg == OPW'(MAX_OUTSTANDING - 1)) ? '0 : ofifo_rd_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (accept) ofifo_mem[ofifo_wr_reg] <= pf_pc_reg;
    if (ibuf_push) ibuf_mem[ibuf_wr_reg] <= ibuf_din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pf_pc_reg     <= PC_RESET;
      inflight_reg  <= '0;
      dcnt_reg      <= '0;
      icnt_reg      <= '0;
      adef_hold_reg <= 1'b0;
      ofifo_wr_reg  <= '0;
      ofifo_rd_reg  <= '0;
      ibuf_wr_reg   <= '0;
      ibuf_rd_reg   <= '0;
    end else begin
      inflight_reg <= inflight_next;
      if (accept) ofifo_wr_reg <= ofifo_wr_next;
      if (resp)   ofifo_rd_reg <= ofifo_rd_next;
      if (redirect) begin
        // Everything still outstanding after this cycle belongs to the old path.
        pf_pc_reg     <= expt_clear ? expt_refresh_pc : br_target;
        dcnt_reg      <= inflight_next;
        icnt_reg      <= '0;
        ibuf_wr_reg   <= '0;
        ibuf_rd_reg   <= '0;
        adef_hold_reg <= 1'b0;
      end else begin
        if (accept) pf_pc_reg <= pf_pc_reg + 32'd4;
        if (resp && dcnt_reg != '0) dcnt_reg <= dcnt_reg - 1'b1;
        icnt_reg <= icnt_reg + IW'(ibuf_push) - IW'(ibuf_pop);
        if (ibuf_push) ibuf_wr_reg <= ibuf_wr_reg + 1'b1;
        if (ibuf_pop)  ibuf_rd_reg <= ibuf_rd_reg + 1'b1;
        if (adef_push) adef_hold_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_stage_prefetch.sv
// Bench for if_stage_prefetch: queue-based reference model checked every cycle,
// a latency-programmable SRAM-like slave, and directed scenarios with literal checks.
module tb_if_stage_prefetch;
  localparam logic [31:0] PC_RESET = 32'h1c000000;
  localparam int MAXO  = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok = 1'b1;
  logic        inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic        br_stall = 1'b0, br_taken = 1'b0, ds_allowin = 1'b1, expt_clear = 1'b0;
  logic [31:0] br_target = 32'h0, expt_refresh_pc = 32'h0;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;

  if_stage_prefetch #(.PC_RESET(PC_RESET), .MAX_OUTSTANDING(MAXO), .IBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .br_stall(br_stall), .br_taken(br_taken), .br_target(br_target),
    .ds_allowin(ds_allowin), .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .expt_clear(expt_clear), .expt_refresh_pc(expt_refresh_pc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mkdata(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  // SRAM-like slave: each accepted address returns in order after lat cycles.
  typedef struct { logic [31:0] addr; int rdy; } bus_req_t;
  bus_req_t bq[$];
  int cyc = 0;
  int lat = 1;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) bq.delete();
      else begin
        if (inst_sram_data_ok && bq.size() > 0) bq.delete(0);
        if (inst_sram_req && inst_sram_addr_ok) bq.push_back('{addr: inst_sram_addr, rdy: cyc + lat});
      end
      @(posedge clk);
      #1;
      cyc++;
      if (bq.size() > 0 && bq[0].rdy <= cyc) begin
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = mkdata(bq[0].addr);
      end else begin
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'hdead_beef;
      end
    end
  end

  // Transaction log: accepted fetch addresses and entries handed to ID.
  logic [31:0] acc_q[$];
  logic [64:0] del_q[$];
  always @(negedge clk) begin
    if (!reset) begin
      if (inst_sram_req && inst_sram_addr_ok) acc_q.push_back(inst_sram_addr);
      if (fs_to_ds_valid && ds_allowin) begin
        del_q.push_back(fs_to_ds_bus);
        $display("deliver: adef=%0b pc=%h inst=%h", fs_to_ds_bus[64], fs_to_ds_bus[63:32], fs_to_ds_bus[31:0]);
      end
    end
  end

  function automatic logic [31:0] del_pc(input int i);
    if (i < del_q.size()) return del_q[i][63:32];
    return 32'hffff_ffff;
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    if (i < acc_q.size()) return acc_q[i];
    return 32'hffff_ffff;
  endfunction

  // Reference model: program-order queues of outstanding fetches and buffered entries.
  logic [31:0] m_pc;
  logic [31:0] m_infl[$];
  logic [64:0] m_ibuf[$];
  int          m_dcnt, m_live, m_isz;
  logic        m_hold, m_redir, e_req, e_valid;
  logic [31:0] m_p;
  always @(negedge clk) begin
    if (reset) begin
      chk("reset_req", inst_sram_req, 0);
      chk("reset_valid", fs_to_ds_valid, 0);
      m_pc = PC_RESET; m_infl.delete(); m_ibuf.delete(); m_dcnt = 0; m_hold = 1'b0;
    end else begin
      m_live  = m_infl.size() - m_dcnt;
      m_isz   = m_ibuf.size();
      m_redir = expt_clear | br_taken;
      e_req   = !br_stall && !m_redir && !m_hold && (m_pc[1:0] == 2'b00)
                && (m_infl.size() < MAXO) && (m_live + m_isz < DEPTH);
      e_valid = (m_isz != 0) && !m_redir;
      chk("req", inst_sram_req, e_req);
      if (e_req) chk("addr", inst_sram_addr, m_pc);
      chk("valid", fs_to_ds_valid, e_valid);
      if (e_valid) chk("bus", fs_to_ds_bus, m_ibuf[0]);
      chk("const_outs", {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata},
          {1'b0, 2'b10, 4'h0, 32'h0});
      if (inst_sram_data_ok) chk("bus_no_underflow", m_infl.size() != 0, 1);

      if (e_valid && ds_allowin) m_ibuf.delete(0);
      if (inst_sram_data_ok && m_infl.size() > 0) begin
        m_p = m_infl[0];
        m_infl.delete(0);
        if (!m_redir) begin
          if (m_dcnt > 0) m_dcnt--;
          else m_ibuf.push_back({1'b0, m_p, inst_sram_rdata});
        end
      end
      if (!m_redir && m_pc[1:0] != 2'b00 && !m_hold && m_live == 0 && m_isz < DEPTH) begin
        m_ibuf.push_back({1'b1, m_pc, 32'h0});
        m_hold = 1'b1;
      end
      if (e_req && inst_sram_addr_ok) begin
        m_infl.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
      if (m_redir) begin
        m_pc   = expt_clear ? expt_refresh_pc : br_target;
        m_ibuf.delete();
        m_hold = 1'b0;
        m_dcnt = m_infl.size();
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    acc_q.delete();
    del_q.delete();
  endtask

  int na, nd;

  initial begin
    // Back-to-back fetch with single-cycle responses.
    lat = 1; ds_allowin = 1'b1;
    do_reset();
    @(negedge clk);
    chk("s1_first_req", inst_sram_req, 1);
    chk("s1_first_addr", inst_sram_addr, PC_RESET);
    tick(8);
    chk("s1_deliver_count", del_q.size(), 6);
    for (int i = 0; i < 4; i++) chk("s1_deliver_pc", del_pc(i), PC_RESET + 32'(4 * i));
    br_stall = 1'b1;
    @(negedge clk);
    chk("s1_stall_blocks_req", inst_sram_req, 0);
    tick(3);
    br_stall = 1'b0;

    // ID stalled: buffer fills to exactly DEPTH, then drains and fetch resumes.
    ds_allowin = 1'b0;
    do_reset();
    tick(10);
    @(negedge clk);
    chk("s2_full_req_low", inst_sram_req, 0);
    chk("s2_full_valid", fs_to_ds_valid, 1);
    chk("s2_head_pc", fs_to_ds_bus[63:32], PC_RESET);
    chk("s2_buffered", acc_q.size(), DEPTH);
    tick(1);
    ds_allowin = 1'b1;
    tick(6);
    for (int i = 0; i < 4; i++) chk("s2_drain_pc", del_pc(i), PC_RESET + 32'(4 * i));
    chk("s2_resume_addr", acc_at(4), 32'h1c000010);

    // Branch while two slow responses are outstanding.
    lat = 5;
    do_reset();
    tick(2);
    br_taken = 1'b1; br_target = 32'h1c000100;
    tick(1);
    br_taken = 1'b0;
    @(negedge clk);
    chk("s3_full_outstanding_req", inst_sram_req, 0);
    tick(14);
    chk("s3_first_after_branch", del_pc(0), 32'h1c000100);
    chk("s3_second_after_branch", del_pc(1), 32'h1c000104);
    chk("s3_third_accept", acc_at(2), 32'h1c000100);

    // Exception and branch in the same cycle: exception wins.
    lat = 1;
    do_reset();
    tick(3);
    expt_clear = 1'b1; expt_refresh_pc = 32'h1c008000;
    br_taken = 1'b1; br_target = 32'h1c000200;
    na = acc_q.size(); nd = del_q.size();
    tick(1);
    expt_clear = 1'b0; br_taken = 1'b0;
    tick(6);
    chk("s4_next_req", acc_at(na), 32'h1c008000);
    chk("s4_next_deliver", del_pc(nd), 32'h1c008000);

    // Misaligned redirect: single adef entry, then fetch halts until redirected.
    expt_clear = 1'b1; expt_refresh_pc = 32'h1c000002;
    na = acc_q.size(); nd = del_q.size();
    tick(1);
    expt_clear = 1'b0;
    tick(8);
    @(negedge clk);
    chk("s5_no_req", inst_sram_req, 0);
    chk("s5_no_valid", fs_to_ds_valid, 0);
    chk("s5_no_accepts", acc_q.size(), na);
    chk("s5_one_entry", del_q.size(), nd + 1);
    chk("s5_adef_entry", (nd < del_q.size()) ? del_q[nd] : 65'h0, {1'b1, 32'h1c000002, 32'h0});
    tick(1);
    br_taken = 1'b1; br_target = 32'h1c000040;
    tick(1);
    br_taken = 1'b0;
    tick(4);
    chk("s5_resume_addr", acc_at(na), 32'h1c000040);

    // Reset in the middle of traffic.
    lat = 3; ds_allowin = 1'b0;
    do_reset();
    tick(6);
    reset = 1'b1;
    @(negedge clk);
    chk("s6_reset_req", inst_sram_req, 0);
    chk("s6_reset_valid", fs_to_ds_valid, 0);
    tick(1);
    reset = 1'b0;
    acc_q.delete(); del_q.delete();
    @(negedge clk);
    chk("s6_post_valid", fs_to_ds_valid, 0);
    chk("s6_post_req", inst_sram_req, 1);
    chk("s6_post_addr", inst_sram_addr, PC_RESET);
    tick(4);
    ds_allowin = 1'b1;
    tick(6);
    chk("s6_first_deliver", del_pc(0), PC_RESET);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
